// File: rtl/roundtrip_result_collector_if.sv
// Upstream average-result stream (valid/ready) into the round-trip result collector.
// master = average stage driving results, slave = collector accepting them.
interface roundtrip_result_collector_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] average_data;
  logic                  average_valid;
  logic                  average_ready;

  modport master (output average_data, output average_valid, input average_ready);
  modport slave  (input average_data, input average_valid, output average_ready);
endinterface

// File: rtl/roundtrip_result_collector.sv
// Buffers per-batch average latency results in a small FIFO for CSR readout and keeps running
// last/count/sum statistics; min/max tracking is built only when ROUNDTRIP_COLLECTOR_MINMAX_EN is defined.
module roundtrip_result_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  roundtrip_result_collector_if.slave       avg_if,
  input  logic                              clear_i,
  input  logic                              pop_i,
  output logic [DATA_WIDTH-1:0]             head_data_o,
  output logic                              fifo_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o,
  output logic                              underflow_o,
  output logic [DATA_WIDTH-1:0]             last_o,
  output logic [COUNT_WIDTH-1:0]            batch_count_o,
  output logic [DATA_WIDTH+COUNT_WIDTH-1:0] sum_o,
  output logic [DATA_WIDTH-1:0]             min_o,
  output logic [DATA_WIDTH-1:0]             max_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SUM_W = DATA_WIDTH + COUNT_WIDTH;

  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [LVL_W-1:0]       r_level;
  logic                   r_underflow;
  logic [DATA_WIDTH-1:0]  r_last;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [SUM_W-1:0]       r_sum;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_cnt_sat;

  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_cnt_sat = (r_count == '1);

  // Clear wins over everything: it blocks the push and swallows a concurrent pop.
  assign avg_if.average_ready = !w_full && !clear_i;
  assign w_push = avg_if.average_valid && avg_if.average_ready;
  assign w_pop  = pop_i && !w_empty && !clear_i;

  // NOTE: storage has no reset; head_data_o is masked while empty, so stale entries are never visible.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_mem[r_wr_ptr] <= avg_if.average_data;
    end
  end

  // Pointers are PTR_W bits wide, so they wrap at FIFO_DEPTH naturally (depth is a power of two).
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_underflow <= 1'b0;
      r_last      <= '0;
      r_count     <= '0;
      r_sum       <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_last   <= avg_if.average_data;
        if (!w_cnt_sat) begin
          r_count <= r_count + 1'b1;
          r_sum   <= r_sum + SUM_W'(avg_if.average_data);
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (pop_i && w_empty) begin
        r_underflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef ROUNDTRIP_COLLECTOR_MINMAX_EN
  logic [DATA_WIDTH-1:0] r_min;
  logic [DATA_WIDTH-1:0] r_max;

  // Extremes keep tracking after the batch counter saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_push) begin
      if (avg_if.average_data < r_min) r_min <= avg_if.average_data;
      if (avg_if.average_data > r_max) r_max <= avg_if.average_data;
    end
  end

  assign min_o = r_min;
  assign max_o = r_max;
`else
  assign min_o = '0;
  assign max_o = '0;
`endif

  assign head_data_o   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_empty_o  = w_empty;
  assign fifo_level_o  = r_level;
  assign underflow_o   = r_underflow;
  assign last_o        = r_last;
  assign batch_count_o = r_count;
  assign sum_o         = r_sum;

endmodule

// File: tb/tb_roundtrip_result_collector.sv
// Self-checking bench for roundtrip_result_collector: a queue scoreboard tracks FIFO contents and
// statistics; expectations for min/max follow ROUNDTRIP_COLLECTOR_MINMAX_EN.
module tb_roundtrip_result_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clear, pop;
  logic clear2, pop2;

  roundtrip_result_collector_if #(.DATA_WIDTH(16)) u_if  ();
  roundtrip_result_collector_if #(.DATA_WIDTH(16)) u_if2 ();

  logic [15:0] head, last, min_v, max_v;
  logic        empty, uf;
  logic [2:0]  level;
  logic [15:0] count;
  logic [31:0] sum;

  logic [15:0] head2, last2, min2, max2;
  logic        empty2, uf2;
  logic [2:0]  level2;
  logic [1:0]  count2;
  logic [17:0] sum2;

  roundtrip_result_collector #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .COUNT_WIDTH(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .avg_if(u_if.slave), .clear_i(clear), .pop_i(pop),
    .head_data_o(head), .fifo_empty_o(empty), .fifo_level_o(level), .underflow_o(uf),
    .last_o(last), .batch_count_o(count), .sum_o(sum), .min_o(min_v), .max_o(max_v)
  );

  roundtrip_result_collector #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .COUNT_WIDTH(2)) u_dut_sat (
    .clk_i(clk), .rst_i(rst), .avg_if(u_if2.slave), .clear_i(clear2), .pop_i(pop2),
    .head_data_o(head2), .fifo_empty_o(empty2), .fifo_level_o(level2), .underflow_o(uf2),
    .last_o(last2), .batch_count_o(count2), .sum_o(sum2), .min_o(min2), .max_o(max2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard for the main instance: FIFO contents plus expected statistics.
  logic [15:0] m_q[$];
  logic [15:0] m_last, m_count, m_min, m_max;
  logic [31:0] m_sum;
  logic        m_uf;

  function automatic logic [15:0] exp_head();
    return (m_q.size() > 0) ? m_q[0] : 16'h0;
  endfunction

  function automatic logic [15:0] exp_min();
`ifdef ROUNDTRIP_COLLECTOR_MINMAX_EN
    return m_min;
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [15:0] exp_max();
`ifdef ROUNDTRIP_COLLECTOR_MINMAX_EN
    return m_max;
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_last = 16'h0; m_count = 16'h0; m_sum = 32'h0;
    m_min = 16'hFFFF; m_max = 16'h0; m_uf = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic [15:0] d, input logic p, input logic c);
    u_if.average_valid = v;
    u_if.average_data  = d;
    pop   = p;
    clear = c;
  endtask

  // One clock of the main instance: predict accept from the model, then advance the model.
  task automatic tick();
    logic        acc;
    logic [15:0] d;
    acc = u_if.average_valid && (m_q.size() < 4) && !clear;
    d   = u_if.average_data;
    @(posedge clk);
    if (clear) begin
      model_clear();
    end else begin
      if (pop) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_uf = 1'b1;
      end
      if (acc) begin
        m_q.push_back(d);
        m_last = d;
        if (m_count != 16'hFFFF) begin
          m_count = m_count + 16'h1;
          m_sum   = m_sum + {16'h0, d};
        end
        if (d < m_min) m_min = d;
        if (d > m_max) m_max = d;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    u_if2.average_valid = 1'b0; u_if2.average_data = 16'h0; pop2 = 1'b0; clear2 = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (head !== 16'h0) begin n_err++; $display("FAIL reset_head got %h exp 0000", head); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
    n_vec++; if (uf !== 1'b0) begin n_err++; $display("FAIL reset_underflow got %b exp 0", uf); end
    n_vec++; if (last !== 16'h0) begin n_err++; $display("FAIL reset_last got %h exp 0000", last); end
    n_vec++; if (count !== 16'h0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL reset_sum got %0d exp 0", sum); end
    model_clear();
    n_vec++; if (min_v !== exp_min()) begin n_err++; $display("FAIL reset_min got %h exp %h", min_v, exp_min()); end
    n_vec++; if (max_v !== 16'h0) begin n_err++; $display("FAIL reset_max got %h exp 0000", max_v); end
    n_vec++; if (u_if.average_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", u_if.average_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] vals [3] = '{16'd10, 16'd30, 16'd20};
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, vals[i], 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL basic_level got %0d exp 3", level); end
    n_vec++; if (head !== exp_head() || head !== 16'd10) begin n_err++; $display("FAIL basic_head got %0d exp 10", head); end
    n_vec++; if (last !== 16'd20) begin n_err++; $display("FAIL basic_last got %0d exp 20", last); end
    n_vec++; if (count !== 16'd3) begin n_err++; $display("FAIL basic_count got %0d exp 3", count); end
    n_vec++; if (sum !== 32'd60) begin n_err++; $display("FAIL basic_sum got %0d exp 60", sum); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL basic_empty got %b exp 0", empty); end
    n_vec++; if (min_v !== exp_min()) begin n_err++; $display("FAIL basic_min got %0d exp %0d", min_v, exp_min()); end
    n_vec++; if (max_v !== exp_max()) begin n_err++; $display("FAIL basic_max got %0d exp %0d", max_v, exp_max()); end
    set_in(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    for (int i = 1; i <= 5; i++) begin
      set_in(1'b1, 16'(i), 1'b0, 1'b0);
      tick();
      n_vec++; if (u_if.average_ready !== (m_q.size() < 4)) begin n_err++; $display("FAIL full_ready[%0d] got %b exp %b", i, u_if.average_ready, m_q.size() < 4); end
    end
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level got %0d exp 4", level); end
    n_vec++; if (u_if.average_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_low got %b exp 0", u_if.average_ready); end
    set_in(1'b1, 16'd5, 1'b1, 1'b0);
    tick();
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL full_pop_level got %0d exp 3", level); end
    n_vec++; if (u_if.average_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_rise got %b exp 1", u_if.average_ready); end
    set_in(1'b1, 16'd5, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_refill_level got %0d exp 4", level); end
    n_vec++; if (head !== exp_head() || head !== 16'd2) begin n_err++; $display("FAIL full_head got %0d exp 2", head); end
    n_vec++; if (last !== 16'd5) begin n_err++; $display("FAIL full_last got %0d exp 5", last); end
    set_in(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, 16'hA1, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'hB2, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'hC3, 1'b1, 1'b0); tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_level got %0d exp 2", level); end
    n_vec++; if (head !== exp_head() || head !== 16'hB2) begin n_err++; $display("FAIL b2b_head got %h exp 00b2", head); end
    for (int i = 1; i <= 6; i++) begin
      set_in(1'b0, 16'h0, 1'b1, 1'b0);
      tick();
      n_vec++; if (level !== 3'(m_q.size())) begin n_err++; $display("FAIL drain_level[%0d] got %0d exp %0d", i, level, m_q.size()); end
      n_vec++; if (head !== exp_head()) begin n_err++; $display("FAIL drain_head[%0d] got %h exp %h", i, head, exp_head()); end
      n_vec++; if (empty !== (m_q.size() == 0)) begin n_err++; $display("FAIL drain_empty[%0d] got %b exp %b", i, empty, m_q.size() == 0); end
      n_vec++; if (uf !== m_uf) begin n_err++; $display("FAIL drain_underflow[%0d] got %b exp %b", i, uf, m_uf); end
    end
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    n_vec++; if (uf !== 1'b1) begin n_err++; $display("FAIL underflow_sticky got %b exp 1", uf); end
  endtask

  task automatic test_clear();
    set_in(1'b1, 16'd9, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'd4, 1'b1, 1'b1);
    #1;
    n_vec++; if (u_if.average_ready !== 1'b0) begin n_err++; $display("FAIL clear_ready got %b exp 0", u_if.average_ready); end
    tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL clear_empty got %b exp 1", empty); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL clear_level got %0d exp 0", level); end
    n_vec++; if (count !== 16'd0) begin n_err++; $display("FAIL clear_count got %0d exp 0", count); end
    n_vec++; if (sum !== 32'd0) begin n_err++; $display("FAIL clear_sum got %0d exp 0", sum); end
    n_vec++; if (last !== 16'd0) begin n_err++; $display("FAIL clear_last got %0d exp 0", last); end
    n_vec++; if (min_v !== exp_min()) begin n_err++; $display("FAIL clear_min got %h exp %h", min_v, exp_min()); end
    n_vec++; if (max_v !== 16'h0) begin n_err++; $display("FAIL clear_max got %h exp 0000", max_v); end
    n_vec++; if (uf !== 1'b0) begin n_err++; $display("FAIL clear_underflow got %b exp 0", uf); end
  endtask

  task automatic test_minmax();
    set_in(1'b1, 16'd7, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'd3, 1'b0, 1'b0); tick();
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    n_vec++; if (min_v !== exp_min()) begin n_err++; $display("FAIL minmax_min got %0d exp %0d", min_v, exp_min()); end
    n_vec++; if (max_v !== exp_max()) begin n_err++; $display("FAIL minmax_max got %0d exp %0d", max_v, exp_max()); end
    n_vec++; if (last !== 16'd3) begin n_err++; $display("FAIL minmax_last got %0d exp 3", last); end
    n_vec++; if (count !== m_count || count !== 16'd2) begin n_err++; $display("FAIL minmax_count got %0d exp 2", count); end
    n_vec++; if (sum !== m_sum || sum !== 32'd10) begin n_err++; $display("FAIL minmax_sum got %0d exp 10", sum); end
    n_vec++; if (head !== exp_head() || head !== 16'd7) begin n_err++; $display("FAIL minmax_head got %0d exp 7", head); end
  endtask

  task automatic test_saturation();
    // Narrow counter instance: five pushes of 1, only four fit in the FIFO.
    for (int i = 0; i < 5; i++) begin
      u_if2.average_valid = 1'b1;
      u_if2.average_data  = 16'd1;
      @(negedge clk);
    end
    u_if2.average_valid = 1'b0;
    n_vec++; if (count2 !== 2'd3) begin n_err++; $display("FAIL sat_count got %0d exp 3", count2); end
    n_vec++; if (sum2 !== 18'd3) begin n_err++; $display("FAIL sat_sum got %0d exp 3", sum2); end
    n_vec++; if (last2 !== 16'd1) begin n_err++; $display("FAIL sat_last got %0d exp 1", last2); end
    n_vec++; if (level2 !== 3'd4) begin n_err++; $display("FAIL sat_level got %0d exp 4", level2); end
    n_vec++; if (head2 !== 16'd1) begin n_err++; $display("FAIL sat_head got %0d exp 1", head2); end
    n_vec++; if (u_if2.average_ready !== 1'b0) begin n_err++; $display("FAIL sat_ready got %b exp 0", u_if2.average_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_clear();
    test_minmax();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
